calc_sequencer: RTL and testbench

Control sequencer for the keyboard calculator. It consumes decoded key events (`key_valid`/`key`) and tracks operand and operator entry. On enter it runs one arithmetic pass, followed by a multi-cycle shift-add-3 binary-to-BCD conversion, so the display path needs no divide/modulo hardware. It drives the five display digit codes `BCD4`..`BCD0` consumed by `mem_addr_gen`.

---
 rtl/calc_sequencer_if.sv | 23 ++
 rtl/calc_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_sequencer_if.sv
// Key-event and display bundle between the keypad decoder, the calculator
// sequencer and the display digit path.
interface calc_sequencer_if;
  logic       key_valid;
  logic [3:0] key;
  logic [3:0] BCD4;
  logic [3:0] BCD3;
  logic [3:0] BCD2;
  logic [3:0] BCD1;
  logic [3:0] BCD0;
  logic       busy;
  logic       done;

  modport master (
    output key_valid, key,
    input  BCD4, BCD3, BCD2, BCD1, BCD0, busy, done
  );

  modport slave (
    input  key_valid, key,
    output BCD4, BCD3, BCD2, BCD1, BCD0, busy, done
  );
endinterface

// File: rtl/calc_sequencer.sv
// Calculator control sequencer: two-digit operand entry, one arithmetic pass,
// then a 14-step shift-add-3 conversion that feeds the display digit codes.
module calc_sequencer (
  input logic            clk,
  input logic            rst,
  calc_sequencer_if.slave bus
);

  localparam logic [2:0] ST_ENT_A = 3'd0;
  localparam logic [2:0] ST_ENT_B = 3'd1;
  localparam logic [2:0] ST_CALC  = 3'd2;
  localparam logic [2:0] ST_CONV  = 3'd3;
  localparam logic [2:0] ST_SHOW  = 3'd4;

  localparam logic [3:0] KEY_ADD   = 4'd10;
  localparam logic [3:0] KEY_SUB   = 4'd11;
  localparam logic [3:0] KEY_MUL   = 4'd12;
  localparam logic [3:0] KEY_ENTER = 4'd15;
  localparam logic [3:0] BLANK     = 4'd15;
  localparam logic [3:0] CONV_LAST = 4'd14;

  logic [2:0]  state_r;
  logic [3:0]  a_tens_r, a_ones_r, b_tens_r, b_ones_r;
  logic [3:0]  op_r;
  logic        neg_r;
  logic [13:0] res_r;
  logic [15:0] acc_r;
  logic [3:0]  cnt_r;
  logic [3:0]  bcd4_r, bcd3_r, bcd2_r, bcd1_r, bcd0_r;
  logic        busy_r, done_r;

  logic        is_digit_s, is_op_s;
  logic [6:0]  a_val_s, b_val_s;
  logic [13:0] calc_s;
  logic        neg_s;
  logic [15:0] adj_s, conv_next_s;
  logic        show3_s, show2_s, show1_s;
  logic [3:0]  s4_s, s3_s, s2_s, s1_s, s0_s;

  function automatic logic [3:0] blank_zero(input logic [3:0] d);
    return (d == 4'd0) ? BLANK : d;
  endfunction

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? (d + 4'd3) : d;
  endfunction

  // Operand values, arithmetic result, conversion step and result formatting.
  always_comb begin
    is_digit_s = (bus.key <= 4'd9);
    is_op_s    = (bus.key == KEY_ADD) || (bus.key == KEY_SUB) || (bus.key == KEY_MUL);
    a_val_s    = {3'd0, a_tens_r} * 7'd10 + {3'd0, a_ones_r};
    b_val_s    = {3'd0, b_tens_r} * 7'd10 + {3'd0, b_ones_r};
    neg_s      = 1'b0;
    case (op_r)
      KEY_ADD: calc_s = {7'd0, a_val_s} + {7'd0, b_val_s};
      KEY_SUB: begin
        if (a_val_s >= b_val_s) begin
          calc_s = {7'd0, a_val_s} - {7'd0, b_val_s};
        end else begin
          calc_s = {7'd0, b_val_s} - {7'd0, a_val_s};
          neg_s  = 1'b1;
        end
      end
      KEY_MUL: calc_s = {7'd0, a_val_s} * {7'd0, b_val_s};
      default: calc_s = 14'd0;
    endcase

    adj_s       = {add3(acc_r[15:12]), add3(acc_r[11:8]), add3(acc_r[7:4]), add3(acc_r[3:0])};
    conv_next_s = (adj_s << 1) | {15'd0, res_r[13]};

    // Leading zeros blank; the sign sits just left of the most significant shown digit.
    show3_s = (acc_r[15:12] != 4'd0);
    show2_s = show3_s || (acc_r[11:8] != 4'd0);
    show1_s = show2_s || (acc_r[7:4] != 4'd0);
    s4_s = BLANK;
    s3_s = show3_s ? acc_r[15:12] : BLANK;
    s2_s = show2_s ? acc_r[11:8]  : BLANK;
    s1_s = show1_s ? acc_r[7:4]   : BLANK;
    s0_s = acc_r[3:0];
    if (neg_r) begin
      if (show3_s) begin
        s4_s = KEY_SUB;
      end else if (show2_s) begin
        s3_s = KEY_SUB;
      end else if (show1_s) begin
        s2_s = KEY_SUB;
      end else begin
        s1_s = KEY_SUB;
      end
    end else begin
      s4_s = BLANK;
    end
  end

  // Sequencer state, operand registers and registered display outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_ENT_A;
      a_tens_r <= 4'd0;
      a_ones_r <= 4'd0;
      b_tens_r <= 4'd0;
      b_ones_r <= 4'd0;
      op_r     <= 4'd0;
      neg_r    <= 1'b0;
      res_r    <= 14'd0;
      acc_r    <= 16'd0;
      cnt_r    <= 4'd0;
      bcd4_r   <= BLANK;
      bcd3_r   <= BLANK;
      bcd2_r   <= BLANK;
      bcd1_r   <= BLANK;
      bcd0_r   <= BLANK;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_ENT_A: begin
          if (bus.key_valid && is_digit_s) begin
            a_tens_r <= a_ones_r;
            a_ones_r <= bus.key;
            bcd4_r   <= BLANK;
            bcd3_r   <= BLANK;
            bcd2_r   <= BLANK;
            bcd1_r   <= blank_zero(a_ones_r);
            bcd0_r   <= bus.key;
          end else if (bus.key_valid && is_op_s) begin
            op_r    <= bus.key;
            bcd4_r  <= blank_zero(a_tens_r);
            bcd3_r  <= a_ones_r;
            bcd2_r  <= bus.key;
            bcd1_r  <= BLANK;
            bcd0_r  <= BLANK;
            state_r <= ST_ENT_B;
          end
        end
        ST_ENT_B: begin
          if (bus.key_valid && is_digit_s) begin
            b_tens_r <= b_ones_r;
            b_ones_r <= bus.key;
            bcd1_r   <= blank_zero(b_ones_r);
            bcd0_r   <= bus.key;
          end else if (bus.key_valid && (bus.key == KEY_ENTER)) begin
            state_r <= ST_CALC;
          end
        end
        ST_CALC: begin
          res_r   <= calc_s;
          neg_r   <= neg_s;
          acc_r   <= 16'd0;
          cnt_r   <= 4'd0;
          busy_r  <= 1'b1;
          state_r <= ST_CONV;
        end
        ST_CONV: begin
          // Fourteen shifts, then one more cycle to publish the formatted result.
          if (cnt_r == CONV_LAST) begin
            bcd4_r  <= s4_s;
            bcd3_r  <= s3_s;
            bcd2_r  <= s2_s;
            bcd1_r  <= s1_s;
            bcd0_r  <= s0_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_SHOW;
          end else begin
            acc_r <= conv_next_s;
            res_r <= {res_r[12:0], 1'b0};
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ST_SHOW: begin
          if (bus.key_valid && is_digit_s) begin
            a_tens_r <= 4'd0;
            a_ones_r <= bus.key;
            b_tens_r <= 4'd0;
            b_ones_r <= 4'd0;
            op_r     <= 4'd0;
            neg_r    <= 1'b0;
            bcd4_r   <= BLANK;
            bcd3_r   <= BLANK;
            bcd2_r   <= BLANK;
            bcd1_r   <= BLANK;
            bcd0_r   <= bus.key;
            state_r  <= ST_ENT_A;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_ENT_A;
        end
      endcase
    end
  end

  assign bus.BCD4 = bcd4_r;
  assign bus.BCD3 = bcd3_r;
  assign bus.BCD2 = bcd2_r;
  assign bus.BCD1 = bcd1_r;
  assign bus.BCD0 = bcd0_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer: entry display, enter timing, results,
// ignored/dropped keys and asynchronous reset during conversion.
module tb_calc_sequencer;
  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [19:0] disp;

  calc_sequencer_if bus ();

  calc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign disp = {bus.BCD4, bus.BCD3, bus.BCD2, bus.BCD1, bus.BCD0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key       = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key       = 4'd0;
  endtask

  task automatic wait_done(output int cycles, output bit timed_out);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    timed_out = (bus.done !== 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.key_valid = 1'b0;
    bus.key = 4'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (disp !== 20'hFFFFF) begin failures++; $display("FAIL reset_disp: got %h expected %h", disp, 20'hFFFFF); end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin failures++; $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", bus.busy, bus.done); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_timing;
    logic exp_busy, exp_done;
    press(4'd1);
    checks++;
    if (disp !== 20'hFFFF1) begin failures++; $display("FAIL add_a1: got %h expected %h", disp, 20'hFFFF1); end
    press(4'd2);
    checks++;
    if (disp !== 20'hFFF12) begin failures++; $display("FAIL add_a2: got %h expected %h", disp, 20'hFFF12); end
    press(4'd10);
    checks++;
    if (disp !== 20'h12AFF) begin failures++; $display("FAIL add_op: got %h expected %h", disp, 20'h12AFF); end
    press(4'd3);
    press(4'd4);
    checks++;
    if (disp !== 20'h12A34) begin failures++; $display("FAIL add_b: got %h expected %h", disp, 20'h12A34); end
    press(4'd15);
    checks++;
    if (bus.busy !== 1'b0) begin failures++; $display("FAIL add_busy_n0: got %b expected 0", bus.busy); end
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      exp_busy = (k <= 15);
      exp_done = (k == 16);
      checks++;
      if (bus.busy !== exp_busy || bus.done !== exp_done) begin
        failures++;
        $display("FAIL add_timing_n%0d: got busy=%b done=%b expected busy=%b done=%b", k, bus.busy, bus.done, exp_busy, exp_done);
      end
      if (k <= 15) begin
        checks++;
        if (disp !== 20'h12A34) begin failures++; $display("FAIL add_hold_n%0d: got %h expected %h", k, disp, 20'h12A34); end
      end
    end
    checks++;
    if (disp !== 20'hFFF46) begin failures++; $display("FAIL add_result: got %h expected %h", disp, 20'hFFF46); end
  endtask

  task automatic test_sub_neg;
    int  cyc;
    bit  to;
    press(4'd5);
    checks++;
    if (disp !== 20'hFFFF5) begin failures++; $display("FAIL sub_a: got %h expected %h", disp, 20'hFFFF5); end
    press(4'd11);
    checks++;
    if (disp !== 20'hF5BFF) begin failures++; $display("FAIL sub_op: got %h expected %h", disp, 20'hF5BFF); end
    press(4'd1);
    press(4'd7);
    checks++;
    if (disp !== 20'hF5B17) begin failures++; $display("FAIL sub_b: got %h expected %h", disp, 20'hF5B17); end
    press(4'd15);
    wait_done(cyc, to);
    checks++;
    if (to || cyc != 16) begin failures++; $display("FAIL sub_latency: got %0d cycles timeout=%0d expected 16", cyc, to); end
    checks++;
    if (disp !== 20'hFFB12) begin failures++; $display("FAIL sub_result: got %h expected %h", disp, 20'hFFB12); end
  endtask

  task automatic test_mul_max;
    int cyc;
    bit to;
    press(4'd9);
    press(4'd9);
    checks++;
    if (disp !== 20'hFFF99) begin failures++; $display("FAIL mul_a: got %h expected %h", disp, 20'hFFF99); end
    press(4'd12);
    checks++;
    if (disp !== 20'h99CFF) begin failures++; $display("FAIL mul_op: got %h expected %h", disp, 20'h99CFF); end
    press(4'd9);
    press(4'd9);
    press(4'd15);
    wait_done(cyc, to);
    checks++;
    if (to) begin failures++; $display("FAIL mul_timeout: got no done expected done"); end
    checks++;
    if (disp !== 20'hF9801) begin failures++; $display("FAIL mul_result: got %h expected %h", disp, 20'hF9801); end
  endtask

  task automatic test_zero;
    int cyc;
    bit to;
    press(4'd0);
    checks++;
    if (disp !== 20'hFFFF0) begin failures++; $display("FAIL zero_a: got %h expected %h", disp, 20'hFFFF0); end
    press(4'd10);
    checks++;
    if (disp !== 20'hF0AFF) begin failures++; $display("FAIL zero_op: got %h expected %h", disp, 20'hF0AFF); end
    press(4'd15);
    wait_done(cyc, to);
    checks++;
    if (to || disp !== 20'hFFFF0) begin failures++; $display("FAIL zero_result: got %h timeout=%0d expected %h", disp, to, 20'hFFFF0); end
  endtask

  task automatic test_ignored;
    int cyc;
    bit to;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    checks++;
    if (disp !== 20'hFFF23) begin failures++; $display("FAIL ign_shift: got %h expected %h", disp, 20'hFFF23); end
    press(4'd13);
    press(4'd14);
    press(4'd15);
    checks++;
    if (disp !== 20'hFFF23 || bus.busy !== 1'b0) begin failures++; $display("FAIL ign_enta: got %h busy=%b expected %h busy=0", disp, bus.busy, 20'hFFF23); end
    press(4'd10);
    checks++;
    if (disp !== 20'h23AFF) begin failures++; $display("FAIL ign_op: got %h expected %h", disp, 20'h23AFF); end
    press(4'd13);
    press(4'd14);
    press(4'd12);
    checks++;
    if (disp !== 20'h23AFF) begin failures++; $display("FAIL ign_entb: got %h expected %h", disp, 20'h23AFF); end
    press(4'd1);
    press(4'd15);
    wait_done(cyc, to);
    checks++;
    if (to || disp !== 20'hFFF24) begin failures++; $display("FAIL ign_result: got %h timeout=%0d expected %h", disp, to, 20'hFFF24); end
    @(negedge clk);
    press(4'd10);
    press(4'd15);
    press(4'd13);
    repeat (3) @(negedge clk);
    checks++;
    if (disp !== 20'hFFF24 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL ign_show: got %h busy=%b done=%b expected %h busy=0 done=0", disp, bus.busy, bus.done, 20'hFFF24);
    end
  endtask

  task automatic test_drop_in_conv;
    int cyc;
    bit to;
    press(4'd4);
    press(4'd10);
    press(4'd5);
    press(4'd15);
    repeat (4) @(negedge clk);
    press(4'd7);
    wait_done(cyc, to);
    checks++;
    if (to || cyc != 11) begin failures++; $display("FAIL drop_latency: got %0d cycles timeout=%0d expected 11", cyc, to); end
    checks++;
    if (disp !== 20'hFFFF9) begin failures++; $display("FAIL drop_result: got %h expected %h", disp, 20'hFFFF9); end
    @(negedge clk);
    press(4'd4);
    checks++;
    if (disp !== 20'hFFFF4) begin failures++; $display("FAIL show_digit: got %h expected %h", disp, 20'hFFFF4); end
  endtask

  task automatic test_reset_mid_conv;
    int cyc;
    bit to;
    press(4'd10);
    checks++;
    if (disp !== 20'hF4AFF) begin failures++; $display("FAIL rmc_op: got %h expected %h", disp, 20'hF4AFF); end
    press(4'd6);
    press(4'd15);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (disp !== 20'hFFFFF || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++;
      $display("FAIL rmc_async: got %h busy=%b done=%b expected FFFFF busy=0 done=0", disp, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    press(4'd2);
    press(4'd10);
    press(4'd3);
    press(4'd15);
    wait_done(cyc, to);
    checks++;
    if (to || disp !== 20'hFFFF5) begin failures++; $display("FAIL rmc_result: got %h timeout=%0d expected %h", disp, to, 20'hFFFF5); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_add_timing();
    test_sub_neg();
    test_mul_max();
    test_zero();
    test_ignored();
    test_drop_in_conv();
    test_reset_mid_conv();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
